ofifo_aligned: RTL and testbench
================================

OFIFO_ALIGNED -- requirements
Module: ofifo_aligned

Interface
- REQ-001: Parameter COL, default 8, number of independent column FIFOs (1..32).
- REQ-002: Parameter PSUM_BW, default 16, bit width of one column entry.
- REQ-003: Parameter DEPTH, default 8, entries per column; SHALL be a power of two, 2..64.
- REQ-004: Parameter AF_LEVEL, default DEPTH-2, almost-full occupancy threshold (1..DEPTH).
- REQ-005: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-006: reset  input  1  asynchronous, active-low reset.
- REQ-007: in  input  COL*PSUM_BW  write data; column i occupies bits [(i+1)*PSUM_BW-1 : i*PSUM_BW].
- REQ-008: wr  input  COL  per-column write request.
- REQ-009: rd  input  1  row read request; pops one entry from every column.
- REQ-010: clr_err  input  1  clears sticky error flags.
- REQ-011: out  output  COL*PSUM_BW  registered row read data, same column packing as in.
- REQ-012: o_valid  output  1  out holds a freshly popped row this cycle.
- REQ-013: o_ready  output  1  every column is non-empty, so a full row is readable.
- REQ-014: o_full  output  1  at least one column is full.
- REQ-015: o_afull  output  1  at least one column has occupancy >= AF_LEVEL.
- REQ-016: o_ovf / o_udf  output  1 each  sticky overflow / underflow flags.

Function
- REQ-017: Each column SHALL be a circular buffer with read/write pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit. Column empty = pointers equal; column full = low bits equal and wrap bits differ.
- REQ-018: A write to column i SHALL be accepted when wr[i]=1 and column i is not full, or when it is full and a read is accepted in the same cycle.
- REQ-019: A read SHALL be accepted when rd=1 and o_ready=1; it advances every column's read pointer by one.
- REQ-020: On an accepted read, out SHALL load the popped row at the next edge and o_valid SHALL be 1 for exactly that one cycle. Latency is 1 cycle. Otherwise o_valid=0 and out holds its value.
- REQ-021: A simultaneous write and read on a column SHALL leave its occupancy unchanged. A write into an empty column is not readable in the same cycle; no fall-through.
- REQ-022: Pointers SHALL wrap modulo DEPTH in the low bits and toggle the wrap bit.
- REQ-023: A write request to a full column with no accepted read SHALL be dropped and SHALL set o_ovf. A read request while o_ready=0 SHALL be ignored and SHALL set o_udf.
- REQ-024: o_ready, o_full and o_afull SHALL be combinational from the pointer state only, never from the current-cycle inputs.
- REQ-025: clr_err=1 SHALL clear both sticky flags at the next edge; a new error in the same cycle takes priority and the flag stays set.

Reset
- REQ-026: Asserting reset low SHALL immediately clear all pointers, out, o_valid, o_ovf and o_udf to 0. The outputs are then o_ready=0, o_full=0, o_afull=0.
- REQ-027: A reset mid-operation SHALL discard all stored entries and any pending read. Memory contents need not be cleared.
- REQ-028: Deassertion SHALL take effect at the first rising clk edge after reset goes high.

Configuration
- REQ-029: The macro OFIFO_ERR_FLAGS_EN controls the error flags. When defined, o_ovf, o_udf and clr_err behave per REQ-023 and REQ-025.
- REQ-030: When OFIFO_ERR_FLAGS_EN is undefined, o_ovf and o_udf SHALL be constant 0, clr_err is ignored, and no flag flops are built. Dropping and ignoring requests is unchanged.

Verification
- REQ-031: Stagger test, COL=8, DEPTH=8: write column i at cycle i with value 0x10+i, then assert rd once o_ready=1. Required: o_ready rises one cycle after the column 7 write; out = {0x17..0x10}; o_valid pulses once, one cycle after rd.
- REQ-032: Fill test: write 8 entries to column 0 only. Required: o_afull=1 after the 6th write, o_full=1 after the 8th; a 9th write sets o_ovf and is dropped; o_ready stays 0.
- REQ-033: Underflow test: after reset, pulse rd. Required: o_valid=0, out=0, o_udf=1; clr_err then clears o_udf at the next edge.
- REQ-034: Full plus read test: with all columns full, assert rd and all wr in the same cycle. Required: o_ovf=0, o_full stays 1, the read data is the oldest row, and the new row is read 8 rows later.
- REQ-035: Wrap test: stream 3*DEPTH rows with rd each cycle once o_ready=1. Required: outputs are in order with no loss across pointer wrap.
- REQ-036: Reset test: assert reset mid-stream with 5 entries stored. Required: o_ready=0 and o_valid=0 immediately; the first post-reset write/read pair returns the new data.

Source files
------------

// File: rtl/ofifo_aligned.sv
// ofifo_aligned: bank of COL independent column FIFOs with a row-wide read.
// Each column is written on its own, but a read pops one entry from every column.
// A read is therefore only possible once all columns hold data. Read data is
// registered, so it appears one cycle after the accepted read.
// Optional feature: define OFIFO_ERR_FLAGS_EN to build the sticky overflow and
// underflow flags (o_ovf/o_udf, cleared by clr_err). Without it they are tied to 0.
module ofifo_aligned #(
  parameter int unsigned COL      = 8,
  parameter int unsigned PSUM_BW  = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COL*PSUM_BW-1:0] in,
  input  logic [COL-1:0]         wr,
  input  logic                   rd,
  input  logic                   clr_err,
  output logic [COL*PSUM_BW-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_afull,
  output logic                   o_ovf,
  output logic                   o_udf
);

  // The pointer has one more bit than the index; that extra MSB is the wrap bit.
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] AF_THRESH = AF_LEVEL[AW:0];
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

  logic [COL-1:0]         col_empty;
  logic [COL-1:0]         col_full;
  logic [COL-1:0]         col_afull;
  logic [COL-1:0]         wr_acc;
  logic [COL*PSUM_BW-1:0] rd_row;
  logic                   rd_acc;
  logic [COL*PSUM_BW-1:0] out_q;
  logic                   valid_q;

  // The status outputs depend only on the pointers, never on this cycle's inputs.
  assign o_ready = &(~col_empty);
  assign o_full  = |col_full;
  assign o_afull = |col_afull;
  assign rd_acc  = rd & o_ready;

  for (genvar i = 0; i < COL; i++) begin : g_col
    logic [AW:0]        wptr_q;
    logic [AW:0]        rptr_q;
    logic [AW:0]        occ;
    logic [PSUM_BW-1:0] mem_q [DEPTH];

    assign occ          = wptr_q - rptr_q;
    assign col_empty[i] = (wptr_q == rptr_q);
    assign col_full[i]  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign col_afull[i] = (occ >= AF_THRESH);
    // A full column can still take a write when the same cycle's read frees a slot.
    assign wr_acc[i]    = wr[i] & (~col_full[i] | rd_acc);
    assign rd_row[i*PSUM_BW +: PSUM_BW] = mem_q[rptr_q[AW-1:0]];

    // Advance the write and read pointers for this column.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_acc[i]) wptr_q <= wptr_q + PTR_ONE;
        if (rd_acc)    rptr_q <= rptr_q + PTR_ONE;
      end
    end

    // Store the accepted write. The storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
      if (wr_acc[i]) mem_q[wptr_q[AW-1:0]] <= in[i*PSUM_BW +: PSUM_BW];
    end
  end

  // Register the popped row and pulse valid for one cycle per accepted read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) out_q <= rd_row;
    end
  end

  assign out     = out_q;
  assign o_valid = valid_q;

`ifdef OFIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;
  logic ovf_set;
  logic udf_set;

  // A write is dropped only when its column is full and no read frees a slot.
  assign ovf_set = (|(wr & col_full)) & ~rd_acc;
  assign udf_set = rd & ~o_ready;

  // Sticky error flags; a new error wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (udf_set)      udf_q <= 1'b1;
      else if (clr_err) udf_q <= 1'b0;
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign o_ovf          = 1'b0;
  assign o_udf          = 1'b0;
`endif

endmodule

// File: tb/tb_ofifo_aligned.sv
// Self-checking bench for ofifo_aligned. It compares the DUT against a queue-based
// reference model, a table of stagger vectors, and directed corner sequences.
// Flag expectations follow OFIFO_ERR_FLAGS_EN in the same way as the design.
module tb_ofifo_aligned;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int DW    = COL * BW;
`ifdef OFIFO_ERR_FLAGS_EN
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam logic FLAGS_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_s;
  logic [COL-1:0] wr_s;
  logic          rd_s;
  logic          clr_s;
  logic [DW-1:0] out;
  logic          o_valid, o_ready, o_full, o_afull, o_ovf, o_udf;

  ofifo_aligned #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in_s),
    .wr     (wr_s),
    .rd     (rd_s),
    .clr_err(clr_s),
    .out    (out),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_full (o_full),
    .o_afull(o_afull),
    .o_ovf  (o_ovf),
    .o_udf  (o_udf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per column, plus the registered outputs and flags.
  logic [BW-1:0] mq [COL][$];
  logic [DW-1:0] m_out;
  logic          m_valid, m_ovf, m_udf;

  typedef struct {
    logic [COL-1:0] wr;
    logic [DW-1:0]  din;
    logic           rd;
    logic           exp_ready;
    logic           exp_valid;
    logic [DW-1:0]  exp_out;
  } vec_t;
  vec_t tv [10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] row_of(input int k);
    logic [DW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = 16'(k * 16 + c + 'h300);
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COL; c++) mq[c].delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // Compare every output with the model's view of the current state.
  task automatic check_model();
    logic m_ready, m_full, m_afull;
    m_ready = 1'b1;
    m_full  = 1'b0;
    m_afull = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (mq[c].size() == 0) m_ready = 1'b0;
      if (mq[c].size() == DEPTH) m_full = 1'b1;
      if (mq[c].size() >= AF) m_afull = 1'b1;
    end
    chk("ready", o_ready, m_ready);
    chk("full", o_full, m_full);
    chk("afull", o_afull, m_afull);
    chk("valid", o_valid, m_valid);
    chk("out", out, m_out);
    chk("ovf", o_ovf, m_ovf);
    chk("udf", o_udf, m_udf);
  endtask

  // One clock cycle: drive, check, clock, update model. Entered and left at posedge+1.
  task automatic step(input logic [COL-1:0] w, input logic [DW-1:0] d, input logic r,
                      input logic c);
    logic           ready, racc;
    logic [COL-1:0] wacc;
    logic [DW-1:0]  row;
    wr_s  = w;
    in_s  = d;
    rd_s  = r;
    clr_s = c;
    #1;
    check_model();
    ready = 1'b1;
    for (int k = 0; k < COL; k++) if (mq[k].size() == 0) ready = 1'b0;
    racc = r && ready;
    for (int k = 0; k < COL; k++) wacc[k] = w[k] && ((mq[k].size() < DEPTH) || racc);
    @(posedge clk);
    if (racc) begin
      for (int k = 0; k < COL; k++) row[k*BW +: BW] = mq[k].pop_front();
      m_out = row;
    end
    m_valid = racc;
    for (int k = 0; k < COL; k++) if (wacc[k]) mq[k].push_back(d[k*BW +: BW]);
`ifdef OFIFO_ERR_FLAGS_EN
    if (|(w & ~wacc)) m_ovf = 1'b1;
    else if (c)       m_ovf = 1'b0;
    if (r && !ready)  m_udf = 1'b1;
    else if (c)       m_udf = 1'b0;
`endif
    #1;
    wr_s  = '0;
    rd_s  = 1'b0;
    clr_s = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_out", out, '0);
    chk("rst_full", o_full, 1'b0);
    chk("rst_afull", o_afull, 1'b0);
    chk("rst_ovf", o_ovf, 1'b0);
    chk("rst_udf", o_udf, 1'b0);
    model_clear();
    wr_s  = '0;
    rd_s  = 1'b0;
    clr_s = 1'b0;
    in_s  = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [COL-1:0] w;
    logic [DW-1:0]  d;
    logic           r, c;
    logic [DW-1:0]  stag_row;

    // Stagger vectors: column k written at cycle k with 0x10+k, then one read.
    for (int k = 0; k < COL; k++) stag_row[k*BW +: BW] = 16'(16'h10 + k);
    for (int k = 0; k < 10; k++) begin
      tv[k].wr        = (k < COL) ? COL'(1) << k : '0;
      tv[k].din       = (k < COL) ? DW'(16'h10 + k) << (BW * k) : '0;
      tv[k].rd        = (k == COL);
      tv[k].exp_ready = (k == COL - 1);
      tv[k].exp_valid = (k == COL);
      tv[k].exp_out   = (k >= COL) ? stag_row : '0;
    end

    reset = 1'b0;
    wr_s  = '0;
    rd_s  = 1'b0;
    clr_s = 1'b0;
    in_s  = '0;
    model_clear();
    #1;
    chk("por_ready", o_ready, 1'b0);
    chk("por_valid", o_valid, 1'b0);
    chk("por_out", out, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Stagger test.
    for (int k = 0; k < 10; k++) begin
      step(tv[k].wr, tv[k].din, tv[k].rd, 1'b0);
      chk("stagger_ready", o_ready, tv[k].exp_ready);
      chk("stagger_valid", o_valid, tv[k].exp_valid);
      chk("stagger_out", out, tv[k].exp_out);
    end

    // Fill column 0 only: afull at 6, full at 8, the 9th write is dropped.
    do_reset();
    for (int n = 1; n <= DEPTH + 1; n++) begin
      step(8'h01, DW'(16'hA0 + n), 1'b0, 1'b0);
      chk("fill_afull", o_afull, logic'(n >= AF));
      chk("fill_full", o_full, logic'(n >= DEPTH));
      chk("fill_ready", o_ready, 1'b0);
    end
    chk("fill_ovf", o_ovf, FLAGS_EN);
    for (int n = 0; n < DEPTH; n++) step(8'hFE, row_of(n), 1'b0, 1'b0);
    for (int n = 0; n < DEPTH; n++) begin
      step('0, '0, 1'b1, 1'b0);
      chk("fill_col0", out[BW-1:0], 16'(16'hA1 + n));
    end
    chk("fill_dropped", o_ready, 1'b0);

    // Underflow: read on an empty FIFO, then clear the flag.
    do_reset();
    step('0, '0, 1'b1, 1'b0);
    chk("udf_valid", o_valid, 1'b0);
    chk("udf_out", out, '0);
    chk("udf_flag", o_udf, FLAGS_EN);
    step('0, '0, 1'b0, 1'b1);
    chk("udf_clear", o_udf, 1'b0);

    // Full plus read: write all columns while full and reading in the same cycle.
    do_reset();
    for (int k = 0; k < DEPTH; k++) step('1, row_of(200 + k), 1'b0, 1'b0);
    step('1, row_of(99), 1'b1, 1'b0);
    chk("fr_ovf", o_ovf, 1'b0);
    chk("fr_full", o_full, 1'b1);
    chk("fr_valid", o_valid, 1'b1);
    chk("fr_oldest", out, row_of(200));
    for (int j = 1; j < DEPTH; j++) begin
      step('0, '0, 1'b1, 1'b0);
      chk("fr_order", out, row_of(200 + j));
    end
    step('0, '0, 1'b1, 1'b0);
    chk("fr_new_row", out, row_of(99));
    chk("fr_empty", o_ready, 1'b0);

    // Wrap: stream 3*DEPTH rows with a read every cycle.
    do_reset();
    step('1, row_of(0), 1'b0, 1'b0);
    for (int k = 1; k <= 3 * DEPTH; k++) begin
      step('1, row_of(k), 1'b1, 1'b0);
      chk("wrap_out", out, row_of(k - 1));
    end
    step('0, '0, 1'b1, 1'b0);
    chk("wrap_last", out, row_of(3 * DEPTH));

    // Reset mid-stream with 5 rows stored and a read pulse in flight.
    do_reset();
    for (int k = 0; k < 6; k++) step('1, row_of(40 + k), 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    chk("mid_valid_before", o_valid, 1'b1);
    do_reset();
    step('1, row_of(77), 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    chk("post_rst_valid", o_valid, 1'b1);
    chk("post_rst_data", out, row_of(77));

    // Randomized traffic: write-heavy phase then read-heavy phase.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      w = (n < 200) ? COL'($urandom() | $urandom()) : COL'($urandom() & $urandom());
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      r = ($urandom_range(0, 99) < ((n < 200) ? 30 : 75));
      c = ($urandom_range(0, 9) == 0);
      step(w, d, r, c);
    end
    #1;
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
